// File: rtl/spi_mem_arbiter.sv
// Arbitrates the shared SPI memory controller between instruction fetch and load/store ports.
// Optional build macro ARB_ROUND_ROBIN_EN selects alternating grants instead of DMEM priority.
package spi_mem_arbiter_pkg;
    typedef enum logic [1:0] {
        TYPE_IMEM_READ  = 2'd0,
        TYPE_DMEM_READ  = 2'd1,
        TYPE_DMEM_WRITE = 2'd2
    } mem_type_t;
endpackage

module spi_mem_arbiter
    import spi_mem_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 2
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic        imem_req_in,
    input  logic [15:0] imem_addr_in,
    output logic        imem_ack_out,
    output logic [15:0] imem_data_out,
    input  logic        dmem_req_in,
    input  logic        dmem_we_in,
    input  logic [15:0] dmem_addr_in,
    input  logic [7:0]  dmem_wdata_in,
    output logic        dmem_ack_out,
    output logic [7:0]  dmem_rdata_out,
    output logic [15:0] ctl_addr_out,
    output logic        ctl_addr_valid_out,
    output logic [7:0]  ctl_wdata_out,
    output mem_type_t   ctl_mem_type_out,
    input  logic [15:0] ctl_flash_data_in,
    input  logic        ctl_flash_valid_in,
    input  logic [7:0]  ctl_psram_data_in,
    input  logic        ctl_psram_valid_in,
    input  logic        ctl_busy_in
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE} state_t;

    state_t      state_q;
    logic [15:0] ctl_addr_q;
    logic        ctl_av_q;
    logic [7:0]  ctl_wdata_q;
    mem_type_t   ctl_type_q;
    logic        imem_ack_q;
    logic [15:0] imem_data_q;
    logic        dmem_ack_q;
    logic [7:0]  dmem_rdata_q;

    logic        grant;
    logic        gnt_imem;
    logic [15:0] gnt_addr;
    mem_type_t   gnt_type;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_q, rr_d;  // 0: IMEM preferred on a tie, 1: DMEM preferred
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] starve_q, starve_d;
`endif

    // The ack cycle blocks a new grant: the requester still shows its old req that cycle.
    always_comb begin
        grant = (state_q == IDLE) && (imem_req_in || dmem_req_in) && !ctl_busy_in
                && !imem_ack_q && !dmem_ack_q;
`ifdef ARB_ROUND_ROBIN_EN
        gnt_imem = imem_req_in && (!dmem_req_in || !rr_q);
        rr_d = rr_q;
        if (grant) rr_d = gnt_imem;
`else
        gnt_imem = imem_req_in && (!dmem_req_in || starve_q == LIMIT);
        starve_d = starve_q;
        if (!imem_req_in) begin
            starve_d = '0;
        end else if (grant) begin
            if (gnt_imem) starve_d = '0;
            else if (starve_q != LIMIT) starve_d = starve_q + 4'd1;
        end
`endif
        gnt_addr = gnt_imem ? imem_addr_in : dmem_addr_in;
        if (gnt_imem)        gnt_type = TYPE_IMEM_READ;
        else if (dmem_we_in) gnt_type = TYPE_DMEM_WRITE;
        else                 gnt_type = TYPE_DMEM_READ;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= IDLE;
            ctl_addr_q   <= '0;
            ctl_av_q     <= 1'b0;
            ctl_wdata_q  <= '0;
            ctl_type_q   <= TYPE_IMEM_READ;
            imem_ack_q   <= 1'b0;
            imem_data_q  <= '0;
            dmem_ack_q   <= 1'b0;
            dmem_rdata_q <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q         <= 1'b0;
`else
            starve_q     <= '0;
`endif
        end else begin
            imem_ack_q <= 1'b0;
            dmem_ack_q <= 1'b0;
            ctl_av_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_q       <= rr_d;
`else
            starve_q   <= starve_d;
`endif
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        ctl_addr_q  <= gnt_addr;
                        ctl_wdata_q <= dmem_wdata_in;
                        ctl_type_q  <= gnt_type;
                        ctl_av_q    <= 1'b1;
                        state_q     <= ISSUE;
                    end
                end
                ISSUE: state_q <= WAIT_START;
                WAIT_START: begin
                    if (ctl_busy_in) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    case (ctl_type_q)
                        TYPE_IMEM_READ: begin
                            if (ctl_flash_valid_in) begin
                                imem_data_q <= ctl_flash_data_in;
                                imem_ack_q  <= 1'b1;
                                state_q     <= IDLE;
                            end
                        end
                        TYPE_DMEM_READ: begin
                            if (ctl_psram_valid_in) begin
                                dmem_rdata_q <= ctl_psram_data_in;
                                dmem_ack_q   <= 1'b1;
                                state_q      <= IDLE;
                            end
                        end
                        TYPE_DMEM_WRITE: begin
                            if (!ctl_busy_in) begin
                                dmem_ack_q <= 1'b1;
                                state_q    <= IDLE;
                            end
                        end
                        default: state_q <= IDLE;
                    endcase
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ctl_addr_out       = ctl_addr_q;
    assign ctl_addr_valid_out = ctl_av_q;
    assign ctl_wdata_out      = ctl_wdata_q;
    assign ctl_mem_type_out   = ctl_type_q;
    assign imem_ack_out       = imem_ack_q;
    assign imem_data_out      = imem_data_q;
    assign dmem_ack_out       = dmem_ack_q;
    assign dmem_rdata_out     = dmem_rdata_q;

endmodule

// File: tb/tb_spi_mem_arbiter.sv
// Bench for spi_mem_arbiter: behavioural SPI controller model, grant/data scoreboards,
// a vector table of single transactions plus arbitration, reset and stray-strobe sequences.
module tb_spi_mem_arbiter;
    import spi_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_in = 1'b0;
    logic [15:0] imem_addr_in = '0;
    logic        imem_ack_out;
    logic [15:0] imem_data_out;
    logic        dmem_req_in = 1'b0;
    logic        dmem_we_in = 1'b0;
    logic [15:0] dmem_addr_in = '0;
    logic [7:0]  dmem_wdata_in = '0;
    logic        dmem_ack_out;
    logic [7:0]  dmem_rdata_out;
    logic [15:0] ctl_addr_out;
    logic        ctl_addr_valid_out;
    logic [7:0]  ctl_wdata_out;
    mem_type_t   ctl_mem_type_out;
    logic [15:0] ctl_flash_data_in;
    logic        ctl_flash_valid_in;
    logic [7:0]  ctl_psram_data_in;
    logic        ctl_psram_valid_in;
    logic        ctl_busy_in;
    logic        stray_v = 1'b0;

    always #5 clk = ~clk;

    spi_mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk_in(clk), .reset_n_in(rst_n),
        .imem_req_in(imem_req_in), .imem_addr_in(imem_addr_in),
        .imem_ack_out(imem_ack_out), .imem_data_out(imem_data_out),
        .dmem_req_in(dmem_req_in), .dmem_we_in(dmem_we_in), .dmem_addr_in(dmem_addr_in),
        .dmem_wdata_in(dmem_wdata_in), .dmem_ack_out(dmem_ack_out), .dmem_rdata_out(dmem_rdata_out),
        .ctl_addr_out(ctl_addr_out), .ctl_addr_valid_out(ctl_addr_valid_out),
        .ctl_wdata_out(ctl_wdata_out), .ctl_mem_type_out(ctl_mem_type_out),
        .ctl_flash_data_in(ctl_flash_data_in), .ctl_flash_valid_in(ctl_flash_valid_in),
        .ctl_psram_data_in(ctl_psram_data_in), .ctl_psram_valid_in(ctl_psram_valid_in),
        .ctl_busy_in(ctl_busy_in)
    );

    function automatic logic [15:0] flash_word(input logic [15:0] a);
        return (a == 16'h0010) ? 16'hA55A : ~a;
    endfunction

    // Controller model: busy for 3 cycles after addr_valid; read strobe lands as busy falls.
    logic [7:0]  psram_mem [0:65535];
    logic        m_busy, m_fv, m_pv;
    logic [15:0] m_fd, m_addr;
    logic [7:0]  m_pd, m_wd;
    mem_type_t   m_type;
    int          m_cnt;

    initial for (int i = 0; i < 65536; i++) psram_mem[i] = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_fv <= 1'b0; m_pv <= 1'b0; m_cnt <= 0;
            m_fd <= '0; m_pd <= '0; m_addr <= '0; m_wd <= '0; m_type <= TYPE_IMEM_READ;
        end else begin
            m_fv <= 1'b0;
            m_pv <= 1'b0;
            if (ctl_addr_valid_out && !m_busy) begin
                m_busy <= 1'b1; m_cnt <= 3;
                m_type <= ctl_mem_type_out; m_addr <= ctl_addr_out; m_wd <= ctl_wdata_out;
            end else if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0;
                    case (m_type)
                        TYPE_IMEM_READ:  begin m_fv <= 1'b1; m_fd <= flash_word(m_addr); end
                        TYPE_DMEM_READ:  begin m_pv <= 1'b1; m_pd <= psram_mem[m_addr]; end
                        default:         psram_mem[m_addr] <= m_wd;
                    endcase
                end
            end
        end
    end

    assign ctl_busy_in        = m_busy;
    assign ctl_flash_valid_in = m_fv | stray_v;
    assign ctl_flash_data_in  = stray_v ? 16'hDEAD : m_fd;
    assign ctl_psram_valid_in = m_pv | stray_v;
    assign ctl_psram_data_in  = stray_v ? 8'h11 : m_pd;

    int n_err = 0;
    int n_chk = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    typedef struct { mem_type_t t; logic [15:0] a; logic [7:0] wd; } gnt_t;
    typedef struct { logic we; logic [7:0] d; } dexp_t;
    gnt_t        gnt_q [$];
    logic [15:0] iexp_q [$];
    dexp_t       dexp_q [$];

    function automatic void push_g(input mem_type_t t, input logic [15:0] a, input logic [7:0] wd);
        gnt_t g;
        g.t = t; g.a = a; g.wd = wd;
        gnt_q.push_back(g);
    endfunction

    // Monitor: pops scoreboards on addr_valid / acks and checks ack latency against strobes.
    bit p_fv, p_pv, p_busy, pp_busy, p_av;
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                p_fv = 0; p_pv = 0; p_busy = 0; pp_busy = 0; p_av = 0;
                continue;
            end
            if (imem_ack_out) begin
                if (iexp_q.size() == 0) chk("imem_ack_unexpected", 32'd1, 32'd0);
                else chk("imem_data", 32'(imem_data_out), 32'(iexp_q.pop_front()));
                chk("imem_ack_lat", 32'(p_fv), 32'd1);
            end
            if (dmem_ack_out) begin
                if (dexp_q.size() == 0) chk("dmem_ack_unexpected", 32'd1, 32'd0);
                else begin
                    dexp_t e;
                    e = dexp_q.pop_front();
                    if (e.we) chk("dwr_ack_lat", 32'({pp_busy, p_busy}), 32'b10);
                    else begin
                        chk("drd_data", 32'(dmem_rdata_out), 32'(e.d));
                        chk("drd_ack_lat", 32'(p_pv), 32'd1);
                    end
                end
            end
            if (ctl_addr_valid_out) begin
                chk("av_pulse", 32'(p_av), 32'd0);
                if (gnt_q.size() == 0) chk("gnt_unexpected", 32'd1, 32'd0);
                else begin
                    gnt_t g;
                    g = gnt_q.pop_front();
                    chk("gnt_type", 32'(ctl_mem_type_out), 32'(g.t));
                    chk("gnt_addr", 32'(ctl_addr_out), 32'(g.a));
                    if (g.t == TYPE_DMEM_WRITE) chk("gnt_wdata", 32'(ctl_wdata_out), 32'(g.wd));
                end
            end
            pp_busy = p_busy; p_busy = ctl_busy_in;
            p_fv = ctl_flash_valid_in; p_pv = ctl_psram_valid_in; p_av = ctl_addr_valid_out;
        end
    end

    task automatic imem_txn(input logic [15:0] a);
        int n;
        iexp_q.push_back(flash_word(a));
        imem_addr_in = a;
        imem_req_in  = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!imem_ack_out && n < 200);
        chk("imem_done", 32'(n < 200), 32'd1);
        imem_req_in = 1'b0;
    endtask

    task automatic dmem_txn(input logic we, input logic [15:0] a, input logic [7:0] wd,
                            input logic [7:0] exp);
        dexp_t e;
        int n;
        e.we = we; e.d = exp;
        dexp_q.push_back(e);
        dmem_we_in = we; dmem_addr_in = a; dmem_wdata_in = wd;
        dmem_req_in = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!dmem_ack_out && n < 200);
        chk("dmem_done", 32'(n < 200), 32'd1);
        dmem_req_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct { bit imem; bit we; logic [15:0] addr; logic [7:0] wd; logic [15:0] exp; } vec_t;
    vec_t tbl [8];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 16'h0010, 8'h00, 16'hA55A};
        tbl[1] = '{1'b0, 1'b1, 16'h0123, 8'h5C, 16'h0000};
        tbl[2] = '{1'b0, 1'b0, 16'h0200, 8'h00, 16'h0000};
        tbl[3] = '{1'b0, 1'b0, 16'h0123, 8'h00, 16'h005C};
        tbl[4] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, 16'h0000};
        tbl[5] = '{1'b0, 1'b1, 16'hFFFF, 8'hA7, 16'h0000};
        tbl[6] = '{1'b0, 1'b0, 16'hFFFF, 8'h00, 16'h00A7};
        tbl[7] = '{1'b1, 1'b0, 16'h0000, 8'h00, 16'hFFFF};

        #12;
        chk("rst_imem_ack", 32'(imem_ack_out), 32'd0);
        chk("rst_dmem_ack", 32'(dmem_ack_out), 32'd0);
        chk("rst_av", 32'(ctl_addr_valid_out), 32'd0);
        chk("rst_type", 32'(ctl_mem_type_out), 32'(TYPE_IMEM_READ));
        chk("rst_addr", 32'(ctl_addr_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single transactions, including addr_valid latency from an idle arbiter
        for (int i = 0; i < 8; i++) begin
            if (tbl[i].imem) push_g(TYPE_IMEM_READ, tbl[i].addr, 8'h00);
            else push_g(tbl[i].we ? TYPE_DMEM_WRITE : TYPE_DMEM_READ, tbl[i].addr, tbl[i].wd);
            fork
                begin
                    if (tbl[i].imem) imem_txn(tbl[i].addr);
                    else dmem_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].exp[7:0]);
                end
                begin
                    int c;
                    c = 0;
                    do begin @(posedge clk); #1; c++; end while (!ctl_addr_valid_out && c < 20);
                    chk("av_lat", 32'(c), 32'd1);
                end
            join
            repeat (2) @(posedge clk);
            #1;
        end

        // Stray strobes while idle: no ack, data outputs hold
        stray_v = 1'b1;
        @(posedge clk); #1;
        stray_v = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("hold_imem_data", 32'(imem_data_out), 32'hFFFF);
        chk("hold_dmem_rdata", 32'(dmem_rdata_out), 32'hA7);

`ifndef ARB_ROUND_ROBIN_EN
        // Simultaneous requests: DMEM first, IMEM still served
        push_g(TYPE_DMEM_READ, 16'h0123, 8'h00);
        push_g(TYPE_IMEM_READ, 16'h0400, 8'h00);
        fork
            imem_txn(16'h0400);
            dmem_txn(1'b0, 16'h0123, 8'h00, 8'h5C);
        join
        repeat (2) @(posedge clk);
        #1;

        // Starvation guard: D,D,I,D,D,I with both ports continuously requesting
        push_g(TYPE_DMEM_WRITE, 16'h0300, 8'h11);
        push_g(TYPE_DMEM_READ,  16'h0300, 8'h00);
        push_g(TYPE_IMEM_READ,  16'h0500, 8'h00);
        push_g(TYPE_DMEM_WRITE, 16'h0301, 8'h22);
        push_g(TYPE_DMEM_READ,  16'h0301, 8'h00);
        push_g(TYPE_IMEM_READ,  16'h0502, 8'h00);
        fork
            begin imem_txn(16'h0500); imem_txn(16'h0502); end
            begin
                dmem_txn(1'b1, 16'h0300, 8'h11, 8'h00);
                dmem_txn(1'b0, 16'h0300, 8'h00, 8'h11);
                dmem_txn(1'b1, 16'h0301, 8'h22, 8'h00);
                dmem_txn(1'b0, 16'h0301, 8'h00, 8'h22);
            end
        join
        repeat (2) @(posedge clk);
        #1;
`endif

        // Reset in the middle of a DMEM read
        push_g(TYPE_DMEM_READ, 16'h0123, 8'hEE);
        dmem_we_in = 1'b0; dmem_addr_in = 16'h0123; dmem_wdata_in = 8'hEE;
        dmem_req_in = 1'b1;
        begin
            int n;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!ctl_busy_in && n < 50);
            chk("rst_seq_busy", 32'(ctl_busy_in), 32'd1);
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dmem_ack", 32'(dmem_ack_out), 32'd0);
        chk("mid_rst_imem_data", 32'(imem_data_out), 32'd0);
        chk("mid_rst_dmem_rdata", 32'(dmem_rdata_out), 32'd0);
        chk("mid_rst_addr", 32'(ctl_addr_out), 32'd0);
        chk("mid_rst_wdata", 32'(ctl_wdata_out), 32'd0);
        chk("mid_rst_type", 32'(ctl_mem_type_out), 32'(TYPE_IMEM_READ));
        chk("mid_rst_av", 32'(ctl_addr_valid_out), 32'd0);
        dmem_req_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_no_ack", 32'({imem_ack_out, dmem_ack_out}), 32'd0);

        // Both ports requesting continuously, two transactions each
`ifdef ARB_ROUND_ROBIN_EN
        push_g(TYPE_IMEM_READ, 16'h0100, 8'h00);
        push_g(TYPE_DMEM_READ, 16'h0123, 8'h00);
        push_g(TYPE_IMEM_READ, 16'h0102, 8'h00);
        push_g(TYPE_DMEM_READ, 16'h0200, 8'h00);
`else
        push_g(TYPE_DMEM_READ, 16'h0123, 8'h00);
        push_g(TYPE_DMEM_READ, 16'h0200, 8'h00);
        push_g(TYPE_IMEM_READ, 16'h0100, 8'h00);
        push_g(TYPE_IMEM_READ, 16'h0102, 8'h00);
`endif
        fork
            begin imem_txn(16'h0100); imem_txn(16'h0102); end
            begin
                dmem_txn(1'b0, 16'h0123, 8'h00, 8'h5C);
                dmem_txn(1'b0, 16'h0200, 8'h00, 8'h00);
            end
        join
        repeat (2) @(posedge clk);
        #1;

        // Normal fetch after the reset
        push_g(TYPE_IMEM_READ, 16'h0010, 8'h00);
        imem_txn(16'h0010);
        repeat (3) @(posedge clk);
        #1;

        chk("gnt_left", 32'(gnt_q.size()), 32'd0);
        chk("iexp_left", 32'(iexp_q.size()), 32'd0);
        chk("dexp_left", 32'(dexp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
